// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-scanline sprite evaluator.
// On line_start, walks the object table through a shared 1-cycle-latency
// read port. It picks up to SLOTS sprites that cover the requested line.
// The selected sprites are committed atomically to the renderer slot outputs.
// Host readback shares the same read port; the scanner has priority.
// Optional feature macro: SPRITE_SCHED_STATS_EN (saturating overflow-line counter).
module sprite_line_scheduler #(
  parameter int MAX_SPRITES = 8,
  parameter int SLOTS       = 4,
  parameter int IDX_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sched_en,
  input  logic                  line_start,
  input  logic [7:0]            next_y,
  output logic                  obj_rd_en,
  output logic [IDX_W-1:0]      obj_rd_addr,
  input  logic [31:0]           obj_rd_data,
  input  logic                  host_req,
  input  logic [IDX_W-1:0]      host_idx,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [31:0]           host_rdata,
  output logic [SLOTS-1:0]      slot_valid,
  output logic [SLOTS*32-1:0]   slot_data,
  output logic [SLOTS*4-1:0]    slot_row,
  output logic                  overflow,
  output logic                  done,
  output logic                  busy,
  output logic [7:0]            overflow_count
);

  localparam int CNT_W = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rd_pend_q, rd_pend_d;
  logic [7:0]         y_q;
  logic               start, commit;

  // Shadow slots are built during the scan; committed slots feed the renderer.
  logic [SLOTS-1:0]   sh_valid_q;
  logic [31:0]        sh_data_q [SLOTS];
  logic [3:0]         sh_row_q  [SLOTS];
  logic [CNT_W-1:0]   hit_cnt_q;
  logic               sh_ovf_q;

  logic [SLOTS-1:0]   com_valid_q;
  logic [31:0]        com_data_q [SLOTS];
  logic [3:0]         com_row_q  [SLOTS];
  logic               com_ovf_q;
  logic               done_q;
  logic               host_rvalid_q;

  // Hit test in 9 bits so that y+h past 255 does not wrap back to the top lines.
  logic [8:0] obj_y9, obj_end9, line_y9;
  logic       hit;
  logic [3:0] hit_row;

  assign obj_y9   = {1'b0, obj_rd_data[15:8]};
  assign obj_end9 = obj_y9 + {5'd0, obj_rd_data[27:24]} + 9'd1;
  assign line_y9  = {1'b0, y_q};
  assign hit      = (line_y9 >= obj_y9) && (line_y9 < obj_end9);
  // Row within sprite; a hit implies the difference is below 16, so the low nibble suffices.
  assign hit_row  = y_q[3:0] - obj_rd_data[11:8];

  // Next-state, read-port arbitration and scan control.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_pend_d   = 1'b0;
    obj_rd_en   = 1'b0;
    obj_rd_addr = '0;
    host_gnt    = 1'b0;
    start       = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!line_start && host_req) begin
          host_gnt    = 1'b1;
          obj_rd_en   = 1'b1;
          obj_rd_addr = host_idx;
        end
      end
      SCAN: begin
        obj_rd_en   = 1'b1;
        obj_rd_addr = idx_q;
        rd_pend_d   = 1'b1;
        if (idx_q == IDX_W'(MAX_SPRITES - 1)) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new line_start always restarts the scan; any in-flight result is discarded.
    if (line_start) begin
      start     = 1'b1;
      commit    = 1'b0;
      rd_pend_d = 1'b0;
      state_d   = SCAN;
      idx_d     = '0;
    end
    // Outputs stay quiet while reset is held.
    if (!rst_n) begin
      host_gnt    = 1'b0;
      obj_rd_en   = 1'b0;
      obj_rd_addr = '0;
    end
  end

  // FSM state, scan index, read-pending flag and latched line number.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rd_pend_q <= 1'b0;
      y_q       <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_pend_q <= rd_pend_d;
      if (start) y_q <= next_y;
    end
  end

  // Shadow slot fill: hits go to slots in ascending index order; extra hits only flag overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      sh_valid_q <= '0;
      hit_cnt_q  <= '0;
      sh_ovf_q   <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        sh_data_q[k] <= 32'd0;
        sh_row_q[k]  <= 4'd0;
      end
    end else if (rd_pend_q && hit) begin
      if (hit_cnt_q < CNT_W'(SLOTS)) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (CNT_W'(k) == hit_cnt_q) begin
            sh_valid_q[k] <= 1'b1;
            sh_data_q[k]  <= obj_rd_data;
            sh_row_q[k]   <= hit_row;
          end
        end
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        sh_ovf_q <= 1'b1;
      end
    end
  end

  // Atomic commit of the shadow set to the renderer and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      com_valid_q <= '0;
      com_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        com_data_q[k] <= 32'd0;
        com_row_q[k]  <= 4'd0;
      end
    end else begin
      done_q <= commit;
      if (commit) begin
        com_valid_q <= sh_valid_q;
        com_ovf_q   <= sh_ovf_q;
        for (int k = 0; k < SLOTS; k++) begin
          com_data_q[k] <= sh_data_q[k];
          com_row_q[k]  <= sh_row_q[k];
        end
      end
    end
  end

  // Host read response is valid one cycle after its grant.
  always_ff @(posedge clk) begin
    if (!rst_n) host_rvalid_q <= 1'b0;
    else        host_rvalid_q <= host_gnt;
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rvalid_q ? obj_rd_data : 32'd0;
  assign slot_valid  = com_valid_q & {SLOTS{sched_en}};
  assign overflow    = com_ovf_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot_out
      assign slot_data[gi*32 +: 32] = com_data_q[gi];
      assign slot_row[gi*4 +: 4]    = com_row_q[gi];
    end
  endgenerate

`ifdef SPRITE_SCHED_STATS_EN
  logic [7:0] ovf_cnt_q;

  // Count committed lines that overflowed, saturating at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt_q <= 8'd0;
    end else if (commit && sh_ovf_q && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign overflow_count = ovf_cnt_q;
`else
  assign overflow_count = 8'd0;
`endif

endmodule
